// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment scan driver: frame-synchronous value update, BCD/hex decode,
// optional leading-zero blanking, active-low segment bus and digit enables.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          HEX_MODE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PcntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PcntW-1:0] PcntLast = PcntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  logic [PcntW-1:0]        r_pcnt;
  logic [IdxW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_bnd;
  logic                    r_frame_done;

  logic                    w_pwrap;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_lz_sel;
  logic                    w_zero_acc;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic                    w_blank;
  logic [6:0]              w_seg_next;

  function automatic logic [6:0] f_decode(input logic [3:0] nib, input bit hex);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = hex ? 7'b0001000 : SegDash;
      4'hB:    s = hex ? 7'b0000011 : SegDash;
      4'hC:    s = hex ? 7'b1000110 : SegDash;
      4'hD:    s = hex ? 7'b0100001 : SegDash;
      4'hE:    s = hex ? 7'b0000110 : SegDash;
      default: s = hex ? 7'b0001110 : SegDash;
    endcase
    return s;
  endfunction

  assign w_pwrap    = (r_pcnt == PcntLast);
  assign w_boundary = w_pwrap && (r_idx == IdxLast);

  // w_lz[k]: nibbles k..NUM_DIGITS-1 of the displayed value are all zero.
  always_comb begin
    w_zero_acc = 1'b1;
    w_lz       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_acc = w_zero_acc & (r_disp[4*k +: 4] == 4'h0);
      w_lz[k]    = w_zero_acc;
    end
  end

  always_comb begin
    w_nib     = 4'h0;
    w_lz_sel  = 1'b0;
    w_an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IdxW'(k) == r_idx) begin
        w_nib        = r_disp[4*k +: 4];
        w_lz_sel     = w_lz[k];
        w_an_next[k] = 1'b0;
      end
    end
  end

  assign w_blank    = blank_lz && (r_idx != '0) && w_lz_sel;
  assign w_seg_next = w_blank ? SegBlank : f_decode(w_nib, HEX_MODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_pending    <= '0;
      r_pend       <= 1'b0;
      r_disp       <= '0;
      r_seg        <= SegBlank;
      r_an         <= '1;
      r_bnd        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_pwrap) begin
        r_pcnt <= '0;
        r_idx  <= (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
      end else begin
        r_pcnt <= r_pcnt + PcntW'(1);
      end

      if (w_boundary && r_pend) begin
        r_disp <= r_pending;
      end

      // A load on the boundary cycle re-arms pend; the boundary moves the old pending value.
      if (load) begin
        r_pending <= value;
        r_pend    <= 1'b1;
      end else if (w_boundary) begin
        r_pend <= 1'b0;
      end

      r_an  <= w_an_next;
      r_seg <= w_seg_next;

      // Delayed one stage so the pulse lines up with an/seg showing digit 0 of the new frame.
      r_bnd        <= w_boundary;
      r_frame_done <= r_bnd;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: BCD and hex instances share stimulus, 4 digits,
// 4-cycle scan (16-cycle frame); expected segment patterns are hand-written constants.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] HA   = 7'b0001000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [6:0]  seg_b, seg_h;
  logic [3:0]  an_b, an_h;
  logic        fd_b, fd_h;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b0)) dut_bcd (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .seg(seg_b), .an(an_b), .frame_done(fd_b)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b1)) dut_hex (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .seg(seg_h), .an(an_h), .frame_done(fd_h)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg_b"}, {25'd0, seg_b}, {25'd0, BLK});
    chk({tag, "_seg_h"}, {25'd0, seg_h}, {25'd0, BLK});
    chk({tag, "_an_b"}, {28'd0, an_b}, 32'hF);
    chk({tag, "_an_h"}, {28'd0, an_h}, 32'hF);
    chk({tag, "_fd"}, {31'd0, fd_b}, 32'd0);
  endtask

  // Align to the first cycle of a frame (an = digit 0), then check one full frame.
  task automatic check_frame(input string tag, input logic [27:0] eb, input logic [27:0] eh);
    logic [3:0] e_an;
    logic       e_fd;
    for (int g = 0; g < 16 && (k % 16) != 1; g++) tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e_an = 4'b1111;
        e_an[d] = 1'b0;
        e_fd = (d == 0) && (c == 0) && (k > 1);
        chk({tag, "_an_b"}, {28'd0, an_b}, {28'd0, e_an});
        chk({tag, "_an_h"}, {28'd0, an_h}, {28'd0, e_an});
        chk({tag, "_seg_b"}, {25'd0, seg_b}, {25'd0, eb[7*d +: 7]});
        chk({tag, "_seg_h"}, {25'd0, seg_h}, {25'd0, eh[7*d +: 7]});
        chk({tag, "_fd"}, {30'd0, fd_h, fd_b}, {30'd0, e_fd, e_fd});
        tick();
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    logic [3:0] e_an;
    logic       e_fd;
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;
    repeat (3) tick();
    chk_reset("rst");

    // Free-running scan of the zero value: an steps every 4 cycles, frame_done every 16.
    rst = 1'b0;
    k   = 0;
    for (int i = 0; i < 33; i++) begin
      tick();
      e_an = 4'b1111;
      e_an[((k - 1) / 4) % 4] = 1'b0;
      e_fd = (k > 1) && ((k % 16) == 1);
      chk("scan_an", {28'd0, an_b}, {28'd0, e_an});
      chk("scan_seg", {25'd0, seg_b}, {25'd0, S0});
      chk("scan_fd", {31'd0, fd_b}, {31'd0, e_fd});
    end

    do_load(16'h1234);
    chk("no_early", {25'd0, seg_b}, {25'd0, S0});
    check_frame("v1234", {S1, S2, S3, S4}, {S1, S2, S3, S4});

    do_load(16'h00A5);
    check_frame("v00A5", {S0, S0, DASH, S5}, {S0, S0, HA, S5});

    blank_lz = 1'b1;
    do_load(16'h0070);
    check_frame("lz0070", {BLK, BLK, S7, S0}, {BLK, BLK, S7, S0});
    do_load(16'h0000);
    check_frame("lz0000", {BLK, BLK, BLK, S0}, {BLK, BLK, BLK, S0});
    do_load(16'h0100);
    check_frame("lz0100", {BLK, S1, S0, S0}, {BLK, S1, S0, S0});
    blank_lz = 1'b0;

    do_load(16'h1111);
    do_load(16'h2222);
    check_frame("last_wins", {S2, S2, S2, S2}, {S2, S2, S2, S2});

    // Load presented on the boundary cycle itself waits one more frame.
    for (int g = 0; g < 16 && (k % 16) != 15; g++) tick();
    do_load(16'h3333);
    check_frame("bnd_old", {S2, S2, S2, S2}, {S2, S2, S2, S2});
    check_frame("bnd_new", {S3, S3, S3, S3}, {S3, S3, S3, S3});

    // Reset while a pending value is waiting and the scan is on digit 2.
    do_load(16'h5555);
    for (int g = 0; g < 16 && (k % 16) != 9; g++) tick();
    chk("pre_rst_an", {28'd0, an_b}, 32'h0000000B);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h5555;
    tick();
    chk_reset("mid_rst");
    rst  = 1'b0;
    load = 1'b0;
    k    = 0;
    tick();
    check_frame("post_rst1", {S0, S0, S0, S0}, {S0, S0, S0, S0});
    check_frame("post_rst2", {S0, S0, S0, S0}, {S0, S0, S0, S0});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit seven-segment display driver, successor to the single-digit BCD decoder. It holds a packed nibble value for NUM_DIGITS digits and time-multiplexes them onto one shared active-low segment bus with active-low digit enables. Features: a BCD or hex decode mode, optional leading-zero blanking, and frame-synchronous value update so a new value never tears mid-scan. It sits between any counter/datapath producing a display value and the board's 7-seg pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal 1..8
- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal >= 2
- HEX_MODE, 0, 0: BCD decode (nibbles A-F show dash); 1: full hex decode
- clk  input  1  system clock; all state on rising edge; single clock domain
- rst  input  1  synchronous, active-high reset
- load  input  1  capture value into pending register this cycle
- value  input  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant)
- blank_lz  input  1  1: blank leading zero digits (digit 0 never blanked)
- seg  output  7  active-low segments {g,f,e,d,c,b,a}
- an  output  NUM_DIGITS  active-low digit enables, exactly one low after reset
- frame_done  output  1  one-cycle pulse at each frame boundary

## Operation
- State: prescaler pcnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), pending register + pend flag, display register disp.
- pcnt increments every cycle; at SCAN_DIV-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Frame boundary = cycle where pcnt==SCAN_DIV-1 and idx==NUM_DIGITS-1. On it: if pend, disp <= pending and pend <= 0; frame_done <= 1 (pulses every boundary, pend or not).
- load: pending <= value, pend <= 1. Multiple loads in one frame: last wins. Load on the boundary cycle itself: boundary transfers the old pending (if any); new value waits for the next boundary.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
- HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. HEX_MODE=0: nibbles A-F -> dash 0111111.
- Leading-zero blanking: when blank_lz=1, digit k>0 shows 1111111 if nibbles k..NUM_DIGITS-1 of disp are all zero. Digit 0 always decoded. Blanked digits still get their an slot (constant scan period). blank_lz is sampled live, not frame-synchronised.
- an <= ~(1<<idx); seg <= decode/blank of disp nibble idx.

## Timing
- Reset values: seg=1111111, an=all ones, frame_done=0, pcnt=0, idx=0, disp=0, pending=0, pend=0.
- seg/an are registered: the first edge with rst low drives an=~1, seg=decode(disp[3:0]). Thereafter an/seg lag idx by one cycle; each digit is displayed for exactly SCAN_DIV cycles; frame period = NUM_DIGITS*SCAN_DIV cycles.
- A load at cycle t reaches seg no earlier than the cycle after the next frame boundary; max latency is one frame plus 1 cycle.
- frame_done is high for the one cycle after the boundary edge, coincident with an returning to digit 0 and with the new disp appearing.
- rst mid-operation: on the next edge all state returns to reset values and pending loads are discarded; load asserted with rst is ignored.
- No combinational path from inputs to outputs.

## Test plan
- Use NUM_DIGITS=4, SCAN_DIV=4 (frame = 16 cycles) unless stated.
- Reset: hold rst 3 cycles -> seg=1111111, an=1111, frame_done=0; release -> next edge an=1110, seg=1000000; an steps 1110,1101,1011,0111 every 4 cycles; frame_done pulses every 16 cycles.
- HEX_MODE=0, load value=16'h1234 -> after next boundary digit0 seg=0011001 (4), digit3 seg=1111001 (1); value=16'h00A5 -> digit1 seg=0111111, digits 2/3 seg=1000000. Same values with HEX_MODE=1 -> digit1 seg=0001000.
- blank_lz=1, value=16'h0070 -> digits 3,2 seg=1111111 with an still scanning; digit1=1111000, digit0=1000000; value=16'h0000 -> only digit0 shows 1000000.
- Load 16'h1111 then 16'h2222 within one frame -> 2222 shown after boundary, 1111 never shown; load 16'h3333 on the boundary cycle -> old value kept one more frame, then 3333.
- Assert rst mid-frame (idx=2, pending loaded) -> next edge outputs reset values, disp=0 after release, pending value never displayed.
